alu_ctrl_mdu: RTL and testbench
===============================

# alu_ctrl_mdu

Parametrised ALU control unit for the pipelined MIPS datapath, sitting in the EX stage. It decodes `ALUOp_i`/`funct_i` into the ALU control code for single-cycle ops and fully defines every input combination. It also owns an iterative multiply/divide unit with HI/LO registers for mult/multu/div/divu/mfhi/mflo. A stall output holds the pipeline while a HI/LO consumer or a second mul/div meets a busy unit.

## Interface

Parameters:
- `DATA_W`, 32, operand and HI/LO width
- `ALUOP_W`, 3, ALUOp width
- `CTRL_W`, 4, ALU control code width
- `CNT_W` (localparam), $clog2(DATA_W)+1, iteration counter width

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  EX-stage instruction valid
- `flush_i`  in  1  abort the in-flight mul/div and suppress a start
- `ALUOp_i`  in  ALUOP_W  op class from main control
- `funct_i`  in  6  R-type function code
- `rs_data_i`  in  DATA_W  mul/div operand A (dividend)
- `rt_data_i`  in  DATA_W  mul/div operand B (divisor)
- `ALUCtrl_o`  out  CTRL_W  ALU control code, combinational
- `md_sel_o`  out  1  writeback takes `md_result_o` (mfhi/mflo), combinational
- `md_result_o`  out  DATA_W  HI for mfhi, else LO
- `hi_o`, `lo_o`  out  DATA_W  HI/LO registers
- `busy_o`  out  1  mul/div in progress, registered
- `stall_o`  out  1  pipeline hold request, combinational

## Operation

- **R-type decode** (`ALUOp_i`=000): addu 100001→0010, subu 100011→0110, and 100100→0000, or 100101→0001, slt 101010→0111, sra 000011→1110, srav 000111→1111.
- **Other ALUOp decode**: 001→0010, 010→0101, 100→0011, 110→1001, 011→1011, 111→0001.
- **Default**: any unlisted combination (including mul/div/mf functs) gives `ALUCtrl_o`=0000. No latches.
- **Mul/div functs**: mult 011000, multu 011001, div 011010, divu 011011. mfhi 010000, mflo 010010.
- **Start condition**: `valid_i` & `ALUOp_i`=000 & mul/div funct & !`flush_i` & state IDLE. The edge latches operands and the op, and enters RUN.
- **States**:
  - IDLE→RUN on start.
  - RUN counts DATA_W iterations, then goes to FIX.
  - FIX→IDLE, writing HI/LO.
- **Signed ops**: operate on magnitudes. FIX applies the signs:
  - product sign = sign A xor sign B;
  - quotient sign = sign A xor sign B;
  - remainder sign = sign A.
- **Multiply**: radix-2 shift-add. The 2·DATA_W product goes to {HI,LO}.
- **Divide**: restoring division. LO=quotient, HI=remainder.
- **Divide by zero**: HI=dividend (`rs_data_i`), LO=all ones. Latency is unchanged.
- **Fixed latency**: latency is the same for all operand values, including zero.
- **`md_sel_o`** = `valid_i` & `ALUOp_i`=000 & funct ∈ {mfhi, mflo}.
- **`stall_o`** = `valid_i` & `ALUOp_i`=000 & funct ∈ {mul/div, mfhi, mflo} & (`busy_o` | state≠IDLE). Other ops never stall and proceed while the unit runs.
- **`flush_i`** in RUN/FIX: return to IDLE at the next edge. HI/LO are unchanged.

## Timing

- **Reset** (async, `rst_i`=0): state IDLE, counter 0, HI=LO=0, `busy_o`=0, internal operand/accumulator registers 0.
- **Reset mid-run**: the run is abandoned immediately and HI/LO read 0.
- **Start cycle**: start is accepted at edge 0. RUN occupies edges 1..DATA_W. FIX writes HI/LO at edge DATA_W+1.
- **`busy_o`**: high for DATA_W+1 cycles, from after edge 0 through edge DATA_W+1.
- **HI/LO visibility**: new values appear on `hi_o`/`lo_o` after edge DATA_W+1, in the same cycle `busy_o` falls.
- **mfhi/mflo during busy**: stalled. It completes in the first cycle with `busy_o`=0 and returns the new value.
- **Back-to-back mul/div**: the second is stalled until IDLE. It is accepted at the edge where `busy_o`=0.
- **Flush with start in the same cycle**: no start.
- **Flush during FIX**: no HI/LO write.

## Structure

- **Shared package `alu_ctrl_pkg`** holds:
  - funct code constants;
  - ALUOp encodings;
  - ALUCtrl codes;
  - FSM state encoding (IDLE/RUN/FIX).
- **Sub-module `mdu_core`**: iterative magnitude multiply/divide datapath with counter, accumulator and sign fix.
- **`alu_ctrl_mdu`**: keeps the decode, start/stall logic and HI/LO registers.

## Test plan

1. **Decode**: ALUOp 000 + funct 100011 → `ALUCtrl_o`=0110. ALUOp 011 → 1011. ALUOp 101 → 0000. ALUOp 000 + funct 011000 → 0000.
2. **Signed multiply**: mult rs=0xFFFFFFFD, rt=7 → `busy_o` high 33 cycles. After edge 33: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. **Divide**:
   - divu 100/7 → LO=14, HI=2.
   - div 0xFFFFFF9C/7 → LO=0xFFFFFFF2, HI=0xFFFFFFFE.
   - div 0x1234/0 → HI=0x1234, LO=0xFFFFFFFF.
4. **mflo stall**: mflo 5 cycles after a mult start → `stall_o`=1 until `busy_o` falls. Next cycle `md_sel_o`=1, `stall_o`=0, `md_result_o`=new LO. An addu issued during the run → `stall_o`=0, `ALUCtrl_o`=0010.
5. **Flush**: `flush_i` at RUN cycle 10 of a mult with prior HI=1, LO=2 → IDLE next edge, `busy_o`=0, HI=1, LO=2.
6. **Reset mid-run**: `rst_i` low mid-run → HI=LO=0 and `busy_o`=0 without a clock.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control / multiply-divide slice:
// R-type function codes, ALUOp classes, ALU control codes, mul/div FSM states
// and small funct classification helpers.
package alu_ctrl_pkg;

  // R-type function codes
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  // ALUOp classes from main control
  localparam logic [2:0] AOP_RTYPE = 3'b000;
  localparam logic [2:0] AOP_ADD   = 3'b001;
  localparam logic [2:0] AOP_010   = 3'b010;
  localparam logic [2:0] AOP_011   = 3'b011;
  localparam logic [2:0] AOP_100   = 3'b100;
  localparam logic [2:0] AOP_110   = 3'b110;
  localparam logic [2:0] AOP_OR    = 3'b111;

  // ALU control codes
  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_OP3  = 4'b0011;
  localparam logic [3:0] C_OP5  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_OP9  = 4'b1001;
  localparam logic [3:0] C_OPB  = 4'b1011;
  localparam logic [3:0] C_SRA  = 4'b1110;
  localparam logic [3:0] C_SRAV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_mf_funct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/alu_ctrl_mdu_core.sv
// mdu_core: iterative magnitude multiply / restoring divide datapath.
// Operands are converted to magnitudes at start, DATA_W iterations run in
// RUN, and FIX applies the result signs; the result is presented while in
// FIX (done_o) for the owner of HI/LO to capture.
//   clk_i, rst_i   clock, async active-low reset
//   start_i        accept a new op (only honoured in IDLE)
//   flush_i        abandon an op in RUN/FIX
//   op_i           funct[1:0]: bit0=unsigned, bit1=divide
//   a_i, b_i       operand A (dividend) / operand B (divisor)
//   busy_o         registered, high while RUN or FIX
//   idle_o         FSM in IDLE
//   done_o         FIX cycle that will commit (not flushed)
//   res_hi_o/lo_o  signed-corrected result, valid with done_o
module mdu_core
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              idle_o,
  output logic              done_o,
  output logic [DATA_W-1:0] res_hi_o,
  output logic [DATA_W-1:0] res_lo_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  md_state_e               state;
  logic [CNT_W-1:0]        cnt;
  logic [2*DATA_W-1:0]     acc;
  logic [DATA_W-1:0]       b_mag;
  logic [DATA_W-1:0]       a_raw;
  logic                    is_div;
  logic                    neg_q;
  logic                    neg_r;
  logic                    div0;

  logic                    op_signed;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_W-1:0]       a_mag;
  logic [DATA_W-1:0]       b_mag_in;

  logic [DATA_W:0]         mul_sum;
  logic [DATA_W:0]         rem_sh;
  logic [DATA_W:0]         rem_diff;
  logic [2*DATA_W-1:0]     mul_next;
  logic [2*DATA_W-1:0]     div_next;
  logic [2*DATA_W-1:0]     prod;
  logic [DATA_W-1:0]       quo;
  logic [DATA_W-1:0]       rem;

  assign op_signed = ~op_i[0];
  assign a_neg     = op_signed & a_i[DATA_W-1];
  assign b_neg     = op_signed & b_i[DATA_W-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag_in  = b_neg ? -b_i : b_i;

  // Both ops load A's magnitude into the low half of acc: it is the
  // multiplier shifted out from the bottom, or the dividend shifted out
  // from the top into the partial remainder.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next = {mul_sum, acc[DATA_W-1:1]};
    rem_sh   = acc[2*DATA_W-1:DATA_W-1];
    rem_diff = rem_sh - {1'b0, b_mag};
    if (rem_sh >= {1'b0, b_mag})
      div_next = {rem_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    else
      div_next = {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = acc[DATA_W-1:0];
    rem  = acc[2*DATA_W-1:DATA_W];
    res_hi_o = prod[2*DATA_W-1:DATA_W];
    res_lo_o = prod[DATA_W-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi_o = a_raw;
        res_lo_o = '1;
      end else begin
        res_hi_o = neg_r ? -rem : rem;
        res_lo_o = neg_q ? -quo : quo;
      end
    end
  end

  assign idle_o = (state == ST_IDLE);
  assign done_o = (state == ST_FIX) & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      b_mag  <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state  <= ST_RUN;
            cnt    <= '0;
            acc    <= {{DATA_W{1'b0}}, a_mag};
            b_mag  <= b_mag_in;
            a_raw  <= a_i;
            is_div <= op_i[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (b_i == '0);
            busy_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1))
              state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decode plus an iterative mul/div unit
// with HI/LO registers and a pipeline stall request.
//   clk_i, rst_i         clock, async active-low reset
//   valid_i, flush_i     EX instruction valid / abort mul/div, block start
//   ALUOp_i, funct_i     op class and R-type function code
//   rs_data_i/rt_data_i  mul/div operands A / B
//   ALUCtrl_o            combinational ALU control code
//   md_sel_o             writeback takes md_result_o (mfhi/mflo)
//   md_result_o          HI for mfhi, otherwise LO
//   hi_o, lo_o           HI/LO registers
//   busy_o               mul/div in progress (registered)
//   stall_o              hold pipeline for HI/LO consumer or second mul/div
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [5:0]         funct_i,
  input  logic [DATA_W-1:0]  rs_data_i,
  input  logic [DATA_W-1:0]  rt_data_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               md_sel_o,
  output logic [DATA_W-1:0]  md_result_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o,
  output logic               busy_o,
  output logic               stall_o
);

  logic              is_rtype;
  logic              is_md;
  logic              is_mf;
  logic              start;
  logic              core_idle;
  logic              core_done;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  assign is_rtype = (ALUOp_i == ALUOP_W'(AOP_RTYPE));
  assign is_md    = is_md_funct(funct_i);
  assign is_mf    = is_mf_funct(funct_i);

  assign start    = valid_i & is_rtype & is_md & ~flush_i & core_idle;
  assign md_sel_o = valid_i & is_rtype & is_mf;
  assign stall_o  = valid_i & is_rtype & (is_md | is_mf) & (busy_o | ~core_idle);

  assign md_result_o = (funct_i == F_MFHI) ? hi_o : lo_o;

  always_comb begin
    ALUCtrl_o = '0;
    if (is_rtype) begin
      case (funct_i)
        F_ADDU:  ALUCtrl_o = CTRL_W'(C_ADD);
        F_SUBU:  ALUCtrl_o = CTRL_W'(C_SUB);
        F_AND:   ALUCtrl_o = CTRL_W'(C_AND);
        F_OR:    ALUCtrl_o = CTRL_W'(C_OR);
        F_SLT:   ALUCtrl_o = CTRL_W'(C_SLT);
        F_SRA:   ALUCtrl_o = CTRL_W'(C_SRA);
        F_SRAV:  ALUCtrl_o = CTRL_W'(C_SRAV);
        default: ALUCtrl_o = '0;
      endcase
    end else begin
      case (ALUOp_i)
        ALUOP_W'(AOP_ADD): ALUCtrl_o = CTRL_W'(C_ADD);
        ALUOP_W'(AOP_010): ALUCtrl_o = CTRL_W'(C_OP5);
        ALUOP_W'(AOP_100): ALUCtrl_o = CTRL_W'(C_OP3);
        ALUOP_W'(AOP_110): ALUCtrl_o = CTRL_W'(C_OP9);
        ALUOP_W'(AOP_011): ALUCtrl_o = CTRL_W'(C_OPB);
        ALUOP_W'(AOP_OR):  ALUCtrl_o = CTRL_W'(C_OR);
        default:           ALUCtrl_o = '0;
      endcase
    end
  end

  // funct[1:0] of mult/multu/div/divu directly encodes {divide, unsigned}
  mdu_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .flush_i  (flush_i),
    .op_i     (funct_i[1:0]),
    .a_i      (rs_data_i),
    .b_i      (rt_data_i),
    .busy_o   (busy_o),
    .idle_o   (core_idle),
    .done_o   (core_done),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (core_done) begin
      hi_o <= res_hi;
      lo_o <= res_lo;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
module tb_alu_ctrl_mdu;

  localparam int W = 32;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] ADDU  = 6'b100001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    aluop = '0;
  logic [5:0]    funct = '0;
  logic [W-1:0]  rs = '0;
  logic [W-1:0]  rt = '0;

  logic [3:0]    ALUCtrl_o;
  logic          md_sel_o;
  logic [W-1:0]  md_result_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;
  logic          busy_o;
  logic          stall_o;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.DATA_W(W), .ALUOP_W(3), .CTRL_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .valid_i     (valid),
    .flush_i     (flush),
    .ALUOp_i     (aluop),
    .funct_i     (funct),
    .rs_data_i   (rs),
    .rt_data_i   (rt),
    .ALUCtrl_o   (ALUCtrl_o),
    .md_sel_o    (md_sel_o),
    .md_result_o (md_result_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy_o      (busy_o),
    .stall_o     (stall_o)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: architectural HI/LO, a pending result and the number
  // of edges left until it lands.
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  logic [2*W-1:0] pend = '0;
  int             remaining = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_md(input logic [5:0] f);
    return f == MULT || f == MULTU || f == DIV || f == DIVU;
  endfunction

  function automatic logic is_mf(input logic [5:0] f);
    return f == MFHI || f == MFLO;
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [2:0] op, input logic [5:0] f);
    if (op != 3'b000) begin
      case (op)
        3'b001:  return 4'b0010;
        3'b010:  return 4'b0101;
        3'b100:  return 4'b0011;
        3'b110:  return 4'b1001;
        3'b011:  return 4'b1011;
        3'b111:  return 4'b0001;
        default: return 4'b0000;
      endcase
    end
    case (f)
      6'b100001: return 4'b0010;
      6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b000011: return 4'b1110;
      6'b000111: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // {HI,LO} from plain 64-bit arithmetic
  function automatic logic [63:0] md_ref(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          q;
    longint          r;
    logic [63:0]     res;
    if (f == MULT) res = sa * sb;
    else if (f == MULTU) res = ua * ub;
    else if (b == 0) res = {a, 32'hFFFF_FFFF};
    else if (f == DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  function automatic logic exp_stall();
    return valid && aluop == 3'b000 && (is_md(funct) || is_mf(funct)) && remaining > 0;
  endfunction

  task automatic model_edge();
    if (remaining > 0) begin
      if (flush) remaining = 0;
      else begin
        remaining--;
        if (remaining == 0) begin
          m_hi = pend[63:32];
          m_lo = pend[31:0];
        end
      end
    end else if (valid && aluop == 3'b000 && is_md(funct) && !flush) begin
      pend = md_ref(funct, rs, rt);
      remaining = W + 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    valid = 1'b1; aluop = 3'b000; funct = f; rs = a; rt = b;
    cycle();
    valid = 1'b0; funct = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      cycle();
      n++;
    end
    chk("wait_idle_bound", {63'd0, busy_o}, 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("aluctrl", {60'd0, ALUCtrl_o}, {60'd0, exp_ctrl(aluop, funct)});
      chk("md_sel", {63'd0, md_sel_o}, {63'd0, valid && aluop == 3'b000 && is_mf(funct)});
      chk("md_result", {32'd0, md_result_o}, {32'd0, (funct == MFHI) ? m_hi : m_lo});
      chk("hi", {32'd0, hi_o}, {32'd0, m_hi});
      chk("lo", {32'd0, lo_o}, {32'd0, m_lo});
      chk("busy", {63'd0, busy_o}, {63'd0, remaining > 0});
      chk("stall", {63'd0, stall_o}, {63'd0, exp_stall()});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [5:0] flist [13] = '{ADDU, 6'b100011, 6'b100100, 6'b100101, 6'b101010,
                             6'b000011, 6'b000111, MULT, MULTU, DIV, DIVU, MFHI, MFLO};

  initial begin
    int n;

    // reset state
    #2;
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    #10 rst_n = 1'b1;

    // decode pins
    aluop = 3'b000; funct = 6'b100011; #1;
    chk("dec_subu", {60'd0, ALUCtrl_o}, 64'h6);
    aluop = 3'b011; #1;
    chk("dec_op011", {60'd0, ALUCtrl_o}, 64'hB);
    aluop = 3'b101; #1;
    chk("dec_op101", {60'd0, ALUCtrl_o}, 64'h0);
    aluop = 3'b000; funct = MULT; #1;
    chk("dec_mult", {60'd0, ALUCtrl_o}, 64'h0);
    funct = '0;
    cycle();

    // signed multiply, busy length
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    n = 0;
    while (busy_o && n < 100) begin
      cycle();
      n++;
    end
    chk("mult_busy_cycles", 64'(n), 64'd33);
    chk("mult_hi", {32'd0, hi_o}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, lo_o}, 64'hFFFF_FFEB);

    // divides
    issue(DIVU, 32'd100, 32'd7);
    wait_idle();
    chk("divu_lo", {32'd0, lo_o}, 64'd14);
    chk("divu_hi", {32'd0, hi_o}, 64'd2);
    issue(DIV, 32'hFFFF_FF9C, 32'd7);
    wait_idle();
    chk("div_lo", {32'd0, lo_o}, 64'hFFFF_FFF2);
    chk("div_hi", {32'd0, hi_o}, 64'hFFFF_FFFE);
    issue(DIV, 32'h1234, 32'd0);
    wait_idle();
    chk("div0_hi", {32'd0, hi_o}, 64'h1234);
    chk("div0_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);

    // addu proceeds during run, mflo stalls until busy falls
    issue(MULTU, 32'h0001_0000, 32'h0001_0003);
    valid = 1'b1; aluop = 3'b000; funct = ADDU;
    repeat (4) begin
      #1;
      chk("addu_nostall", {63'd0, stall_o}, 64'd0);
      chk("addu_ctrl", {60'd0, ALUCtrl_o}, 64'h2);
      cycle();
    end
    funct = MFLO; #1;
    chk("mflo_stall", {63'd0, stall_o}, 64'd1);
    n = 0;
    while (stall_o && n < 100) begin
      cycle();
      n++;
    end
    chk("mflo_stall_cycles", 64'(n), 64'd29);
    chk("mflo_busy", {63'd0, busy_o}, 64'd0);
    chk("mflo_sel", {63'd0, md_sel_o}, 64'd1);
    chk("mflo_result", {32'd0, md_result_o}, 64'h0003_0000);
    chk("multu_hi", {32'd0, hi_o}, 64'd1);
    cycle();
    valid = 1'b0; funct = '0;

    // set HI=1, LO=2, then flush mid-run
    issue(MULTU, 32'd2, 32'h8000_0001);
    wait_idle();
    chk("setup_hi", {32'd0, hi_o}, 64'd1);
    chk("setup_lo", {32'd0, lo_o}, 64'd2);
    issue(MULT, 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (9) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    chk("flush_hi", {32'd0, hi_o}, 64'd1);
    chk("flush_lo", {32'd0, lo_o}, 64'd2);

    // flush with start in the same cycle
    flush = 1'b1;
    issue(MULT, 32'd5, 32'd6);
    flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy_o}, 64'd0);

    // flush during FIX
    issue(MULT, 32'd3, 32'd5);
    repeat (32) cycle();
    chk("fix_busy", {63'd0, busy_o}, 64'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("fixflush_busy", {63'd0, busy_o}, 64'd0);
    chk("fixflush_hi", {32'd0, hi_o}, 64'd1);
    chk("fixflush_lo", {32'd0, lo_o}, 64'd2);

    // reset mid-run, no clock edge needed
    issue(MULT, 32'd9, 32'd9);
    repeat (5) cycle();
    #2 rst_n = 1'b0;
    m_hi = '0; m_lo = '0; remaining = 0;
    #1;
    chk("rstrun_hi", {32'd0, hi_o}, 64'd0);
    chk("rstrun_lo", {32'd0, lo_o}, 64'd0);
    chk("rstrun_busy", {63'd0, busy_o}, 64'd0);
    #10 rst_n = 1'b1;
    cycle();

    // back-to-back: second op waits for IDLE
    valid = 1'b1; aluop = 3'b000; funct = MULT; rs = 32'h1234_5678; rt = 32'hFEDC_BA98;
    cycle();
    funct = DIVU; rs = 32'd1000; rt = 32'd3;
    n = 0;
    while (stall_o && n < 100) begin
      cycle();
      n++;
    end
    chk("b2b_stall_cycles", 64'(n), 64'd33);
    cycle();
    valid = 1'b0; funct = '0;
    chk("b2b_accept", {63'd0, busy_o}, 64'd1);
    wait_idle();
    chk("b2b_lo", {32'd0, lo_o}, 64'd333);
    chk("b2b_hi", {32'd0, hi_o}, 64'd1);

    // randomized traffic; a stalled instruction is held
    for (int i = 0; i < 4000; i++) begin
      if (!exp_stall()) begin
        valid = ($urandom_range(0, 9) != 0);
        flush = ($urandom_range(0, 24) == 0);
        aluop = ($urandom_range(0, 2) != 0) ? 3'b000 : 3'($urandom_range(0, 7));
        funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : flist[$urandom_range(0, 12)];
        rs = rnd_operand();
        rt = rnd_operand();
      end
      cycle();
    end
    valid = 1'b0; flush = 1'b0; funct = '0; aluop = '0;
    repeat (40) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
